// File: rtl/otp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otp_pkg
//  Description : Shared sequencer state encoding and safe-idle macro levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package otp_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SETUP   = 4'd1,
        RD_STB  = 4'd2,
        RD_CAP  = 4'd3,
        PG_SCAN = 4'd4,
        PG_STB  = 4'd5,
        PG_GAP  = 4'd6,
        HOLD    = 4'd7,
        DONE    = 4'd8
    } otp_state_t;

    // Macro pin levels that leave the array deselected and unpowered
    localparam logic c_safe_csb    = 1'b1;
    localparam logic c_safe_strobe = 1'b0;
    localparam logic c_safe_load   = 1'b0;
    localparam logic c_safe_pgenb  = 1'b1;
    localparam logic c_safe_vddqsw = 1'b0;

    function automatic int otp_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : otp_pkg
`default_nettype wire

// File: rtl/otp_tcnt.sv
`default_nettype none
// ============================================================================
//  Module      : otp_tcnt
//  Description : Loadable down-counter with zero flag for macro phase timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module otp_tcnt #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : otp_tcnt
`default_nettype wire

// File: rtl/otp_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : otp_seq_ctrl
//  Description : OTP macro sequencer: burst word reads and bitwise programming.
//  Revision    : 1.0 - initial release
// ============================================================================
module otp_seq_ctrl
    import otp_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int BIT_W  = $clog2(DATA_W),
    parameter int T_SU   = 2,
    parameter int T_RD   = 3,
    parameter int T_PG   = 40
) (
    input  logic                    xtal_clk,
    input  logic                    por_rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [3:0]              req_len,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    done,
    output logic                    o_otp_csb,
    output logic                    o_otp_strobe,
    output logic                    o_otp_load,
    output logic                    o_otp_pgenb,
    output logic                    o_otp_vddqsw,
    output logic [ADDR_W+BIT_W-1:0] o_otp_addr,
    input  logic [DATA_W-1:0]       i_otp_q
);

    localparam int CNT_W = $clog2(otp_max3(T_SU, T_RD, T_PG) + 1);

    localparam logic [CNT_W-1:0] c_ld_su = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] c_ld_rd = CNT_W'(T_RD - 1);
    localparam logic [CNT_W-1:0] c_ld_pg = CNT_W'(T_PG - 1);
    localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(DATA_W - 1);

    otp_state_t              r_state;
    logic                    r_write;
    logic [ADDR_W-1:0]       r_word;
    logic [3:0]              r_left;
    logic [DATA_W-1:0]       r_wdata;
    logic [BIT_W-1:0]        r_bit;
    logic                    r_csb;
    logic                    r_strobe;
    logic                    r_load;
    logic                    r_pgenb;
    logic                    r_vddqsw;
    logic [ADDR_W+BIT_W-1:0] r_addr;
    logic [DATA_W-1:0]       r_rd_data;
    logic                    r_rd_valid;
    logic                    r_rd_last;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_last_bit;
    logic                    w_cur_bit;
    logic [ADDR_W-1:0]       w_word_inc;
    logic                    w_cnt_load;
    logic [CNT_W-1:0]        w_cnt_val;
    logic                    w_cnt_zero;

    assign req_ready  = (r_state == IDLE) && !por_rst;
    assign w_accept   = req_valid && req_ready;
    assign w_last_bit = (r_bit == c_last_bit);
    assign w_cur_bit  = r_wdata[r_bit];
    assign w_word_inc = r_word + 1'b1;

    // Counter is loaded on the same edge the FSM enters a timed phase
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_ld_su;
                end
            end
            SETUP: begin
                if (w_cnt_zero && !r_write) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_ld_rd;
                end
            end
            RD_CAP: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = (r_left == 4'd0) ? c_ld_su : c_ld_rd;
            end
            PG_SCAN: begin
                if (w_cur_bit) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_ld_pg;
                end else if (w_last_bit) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_ld_su;
                end
            end
            PG_GAP: begin
                if (w_last_bit) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_ld_su;
                end
            end
            default: begin
                w_cnt_load = 1'b0;
                w_cnt_val  = '0;
            end
        endcase
    end

    otp_tcnt #(
        .WIDTH      (CNT_W)
    ) u_tcnt (
        .clk        (xtal_clk),
        .rst        (por_rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge xtal_clk or posedge por_rst) begin
        if (por_rst) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_word     <= '0;
            r_left     <= '0;
            r_wdata    <= '0;
            r_bit      <= '0;
            r_csb      <= c_safe_csb;
            r_strobe   <= c_safe_strobe;
            r_load     <= c_safe_load;
            r_pgenb    <= c_safe_pgenb;
            r_vddqsw   <= c_safe_vddqsw;
            r_addr     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write  <= req_write;
                        r_word   <= req_addr;
                        r_left   <= req_len;
                        r_wdata  <= req_wdata;
                        r_bit    <= '0;
                        r_addr   <= {req_addr, {BIT_W{1'b0}}};
                        r_csb    <= 1'b0;
                        r_load   <= !req_write;
                        r_pgenb  <= !req_write;
                        r_vddqsw <= req_write;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_cnt_zero) begin
                        if (r_write) begin
                            r_state <= PG_SCAN;
                        end else begin
                            r_strobe <= 1'b1;
                            r_addr   <= {r_word, {BIT_W{1'b0}}};
                            r_state  <= RD_STB;
                        end
                    end
                end
                RD_STB: begin
                    if (w_cnt_zero) begin
                        r_strobe <= 1'b0;
                        r_state  <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    r_rd_data  <= i_otp_q;
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= (r_left == 4'd0);
                    if (r_left == 4'd0) begin
                        r_state <= HOLD;
                    end else begin
                        r_left   <= r_left - 1'b1;
                        r_word   <= w_word_inc;
                        r_addr   <= {w_word_inc, {BIT_W{1'b0}}};
                        r_strobe <= 1'b1;
                        r_state  <= RD_STB;
                    end
                end
                PG_SCAN: begin
                    if (w_cur_bit) begin
                        r_strobe <= 1'b1;
                        r_addr   <= {r_word, r_bit};
                        r_state  <= PG_STB;
                    end else if (w_last_bit) begin
                        r_state <= HOLD;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
                PG_STB: begin
                    if (w_cnt_zero) begin
                        r_strobe <= 1'b0;
                        r_state  <= PG_GAP;
                    end
                end
                PG_GAP: begin
                    if (w_last_bit) begin
                        r_state <= HOLD;
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_state <= PG_SCAN;
                    end
                end
                HOLD: begin
                    if (w_cnt_zero) begin
                        r_csb    <= c_safe_csb;
                        r_load   <= c_safe_load;
                        r_pgenb  <= c_safe_pgenb;
                        r_vddqsw <= c_safe_vddqsw;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_csb    <= c_safe_csb;
                    r_strobe <= c_safe_strobe;
                    r_load   <= c_safe_load;
                    r_pgenb  <= c_safe_pgenb;
                    r_vddqsw <= c_safe_vddqsw;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign rd_last      = r_rd_last;
    assign o_otp_csb    = r_csb;
    assign o_otp_strobe = r_strobe;
    assign o_otp_load   = r_load;
    assign o_otp_pgenb  = r_pgenb;
    assign o_otp_vddqsw = r_vddqsw;
    assign o_otp_addr   = r_addr;

endmodule : otp_seq_ctrl
`default_nettype wire
